// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM compare block and its wrap detector.
package pwm_pkg;

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned PCNT_W_DEF = 16;

    localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [PCNT_W_DEF-1:0] PCNT_MAX = {PCNT_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SYNC = 2'b01,
        ST_RUN  = 2'b10
    } pwm_state_e;

endpackage

// File: rtl/pwm_compare_wrap_detect.sv
// Detects the all-ones -> zero transition of a free-running up-count.
module wrap_detect
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_i,
    output logic             wrap_det_c
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= count_i;
        end
    end

    // An upstream counter reset from any value other than all-ones is not a wrap.
    assign wrap_det_c = (prev_q == ALL_ONES) && (count_i == '0);

endmodule

// File: rtl/pwm_compare.sv
// PWM generator driven by an external up-count; duty updates are shadowed and applied at wrap.
module pwm_compare
    import pwm_pkg::*;
#(
    parameter int unsigned      WIDTH     = CNT_W,
    parameter logic [WIDTH-1:0] INIT_DUTY = '0,
    parameter int unsigned      PCNT_W    = PCNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  count,
    input  logic [WIDTH-1:0]  duty_in,
    input  logic              duty_valid,
    output logic              duty_ready,
    output logic              pwm,
    output logic              wrap,
    output logic [PCNT_W-1:0] period_cnt
);

    localparam logic [PCNT_W-1:0] PCNT_SAT = {PCNT_W{1'b1}};

    pwm_state_e        state_q, state_d;
    logic [WIDTH-1:0]  active_q, active_d;
    logic [WIDTH-1:0]  shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic              pwm_q, pwm_d;
    logic              wrap_q, wrap_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;

    logic              wrap_det;
    logic              xfer;
    logic [WIDTH-1:0]  duty_eff;

    wrap_detect #(
        .WIDTH (WIDTH)
    ) u_wrap_detect (
        .clk        (clk),
        .rst        (rst),
        .count_i    (count),
        .wrap_det_c (wrap_det)
    );

    assign xfer = duty_valid && !pending_q;

    // Duty used for the period that starts at this wrap; a same-cycle transfer bypasses the shadow.
    always_comb begin
        duty_eff = active_q;
        if (wrap_det && pending_q) begin
            duty_eff = shadow_q;
        end else if (wrap_det && xfer) begin
            duty_eff = duty_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            active_q  <= INIT_DUTY;
            shadow_q  <= INIT_DUTY;
            pending_q <= 1'b0;
            pwm_q     <= 1'b0;
            wrap_q    <= 1'b0;
            pcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pwm_q     <= pwm_d;
            wrap_q    <= wrap_d;
            pcnt_q    <= pcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pwm_d     = 1'b0;
        wrap_d    = 1'b0;
        pcnt_d    = pcnt_q;

        if (!en) begin
            // Disable wins; a shadowed value survives to be applied after re-sync.
            state_d = ST_IDLE;
            pcnt_d  = '0;
            if (xfer) begin
                shadow_d = duty_in;
                if (state_q == ST_IDLE) begin
                    active_d = duty_in;
                end else begin
                    pending_d = 1'b1;
                end
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    pcnt_d  = '0;
                    state_d = ST_SYNC;
                    if (xfer) begin
                        shadow_d = duty_in;
                        active_d = duty_in;
                    end
                end
                ST_SYNC: begin
                    if (wrap_det) begin
                        // The wrap edge is the first cycle of the first full period.
                        state_d   = ST_RUN;
                        active_d  = duty_eff;
                        shadow_d  = duty_eff;
                        pending_d = 1'b0;
                        pwm_d     = (count < duty_eff);
                    end else if (xfer) begin
                        shadow_d  = duty_in;
                        pending_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    pwm_d = (count < duty_eff);
                    if (wrap_det) begin
                        active_d  = duty_eff;
                        shadow_d  = duty_eff;
                        pending_d = 1'b0;
                        wrap_d    = 1'b1;
                        if (pcnt_q != PCNT_SAT) begin
                            pcnt_d = pcnt_q + PCNT_W'(1);
                        end
                    end else if (xfer) begin
                        shadow_d  = duty_in;
                        pending_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign duty_ready = !pending_q;
    assign pwm        = pwm_q;
    assign wrap       = wrap_q;
    assign period_cnt = pcnt_q;

endmodule

// File: tb/tb_pwm_compare.sv
// Scoreboard bench for pwm_compare: a per-cycle reference model queues expectations, a monitor checks them.
module tb_pwm_compare;

    localparam int unsigned PW   = 3;
    localparam int          PSAT = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en;
    logic [7:0]    count;
    logic [7:0]    duty_in;
    logic          duty_valid;
    logic          duty_ready;
    logic          pwm;
    logic          wrap;
    logic [PW-1:0] period_cnt;

    typedef struct packed {
        logic          pwm;
        logic          wrap;
        logic [PW-1:0] pcnt;
        logic          ready;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic rdy_neg  = 1'b1;

    // Reference model state: enabled / aligned to a period, this period's duty, queued duty.
    bit m_on, m_aligned, m_pending;
    int m_duty, m_next, m_pcnt, m_prev;

    pwm_compare #(
        .WIDTH     (8),
        .INIT_DUTY (8'd0),
        .PCNT_W    (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .count      (count),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .pwm        (pwm),
        .wrap       (wrap),
        .period_cnt (period_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_on = 0; m_aligned = 0; m_pending = 0;
        m_duty = 0; m_next = 0; m_pcnt = 0; m_prev = 0;
    endtask

    task automatic model_step(output exp_t e);
        bit wrapped, take, p, w;
        int d;
        wrapped = (m_prev == 255) && (int'(count) == 0);
        take    = duty_valid && !m_pending;
        p = 0; w = 0;
        if (!en) begin
            if (take) begin
                m_next = duty_in;
                if (m_on) m_pending = 1; else m_duty = duty_in;
            end
            m_on = 0; m_aligned = 0; m_pcnt = 0;
        end else if (!m_on) begin
            if (take) begin m_duty = duty_in; m_next = duty_in; end
            m_on = 1; m_pcnt = 0;
        end else if (wrapped) begin
            d = m_pending ? m_next : (take ? int'(duty_in) : m_duty);
            p = (d > 0);
            if (m_aligned) begin
                w = 1;
                if (m_pcnt < PSAT) m_pcnt++;
            end
            m_aligned = 1; m_duty = d; m_next = d; m_pending = 0;
        end else begin
            if (m_aligned) p = (int'(count) < m_duty);
            if (take) begin m_next = duty_in; m_pending = 1; end
        end
        m_prev = int'(count);
        e = '{pwm: p, wrap: w, pcnt: PW'(m_pcnt), ready: !m_pending};
    endtask

    always @(posedge clk or negedge rst) begin : model_p
        exp_t e;
        if (!rst) begin
            model_reset();
            sb.delete();
            sb.push_back('{pwm: 1'b0, wrap: 1'b0, pcnt: '0, ready: 1'b1});
        end else begin
            model_step(e);
            sb.push_back(e);
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon_p
        exp_t e;
        rdy_neg = duty_ready;
        if (sb.size() == 0) begin
            if (rst === 1'b1) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
            end
        end else begin
            e = sb.pop_front();
            check("pwm",        32'(pwm),        32'(e.pwm));
            check("wrap",       32'(wrap),       32'(e.wrap));
            check("period_cnt", 32'(period_cnt), 32'(e.pcnt));
            check("duty_ready", 32'(duty_ready), 32'(e.ready));
        end
    end

    task automatic step();
        bit acc;
        @(posedge clk);
        acc = duty_valid && rdy_neg;
        #1;
        if (acc) duty_valid = 1'b0;
        count = count + 8'd1;
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic run_to(int v);
        for (int i = 0; i < 600 && int'(count) != v; i++) step();
    endtask

    task automatic wait_accept(int bound);
        for (int i = 0; i < bound && duty_valid; i++) step();
        n_checks++;
        if (duty_valid) begin
            n_fail++;
            $display("FAIL accept_timeout: got valid=1 expected accepted within %0d cycles", bound);
            duty_valid = 1'b0;
        end
    endtask

    task automatic send(int v, int bound);
        duty_in    = 8'(v);
        duty_valid = 1'b1;
        wait_accept(bound);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        en = 1'b0; count = 8'd0; duty_valid = 1'b0; duty_in = 8'd0;
        #12 rst = 1'b1;
        run(3);
        send(64, 4);                       // IDLE write goes straight to active duty
        en = 1'b1;
        run(256 * 3);
        run_to(100);
        send(200, 4);                      // shadowed until the next wrap
        run(256 * 2);
        run_to(255);
        step();
        send(10, 2);                       // transfer on the wrap cycle bypasses the shadow
        run(300);
        run_to(50);
        send(0, 4);
        run(512);
        run_to(50);
        send(255, 4);
        run(512);
        run_to(40);
        send(128, 4);
        duty_in = 8'd32; duty_valid = 1'b1;
        wait_accept(300);                  // held valid taken once ready returns
        run(256);
        run_to(100);
        count = 8'd0;                      // upstream counter reset: not a wrap
        run(300);
        run_to(20);
        send(77, 4);
        run_to(30);
        en = 1'b0;
        run(5);
        en = 1'b1;
        run(600);
        run_to(80);
        #2 rst = 1'b0;
        #4 rst = 1'b1;
        run(600);
        send(64, 4);
        run(300);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_compare.md
Name: pwm_compare

Overview:
- Consumes the free-running 8-bit count produced by the team's up counter (up_counter) and generates a PWM waveform from it.
- Duty-cycle updates arrive through a valid/ready handshake. They are held in a shadow register and applied only at a counter wrap, so no glitched periods occur.
- Also emits a one-cycle wrap pulse and a saturating count of completed periods for status logic downstream.

Parameters:
- WIDTH, 8, width of count and duty; must match the upstream counter.
- INIT_DUTY, 0, active and shadow duty value after reset.
- PCNT_W, 16, width of period_cnt.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  run enable; 0 forces IDLE.
- count  input  WIDTH  free-running up-count from the upstream counter.
- duty_in  input  WIDTH  new duty value.
- duty_valid  input  1  duty_in is valid.
- duty_ready  output  1  block can accept duty_in this cycle.
- pwm  output  1  registered PWM output.
- wrap  output  1  one-cycle pulse per completed period in RUN.
- period_cnt  output  PCNT_W  completed periods since entering RUN; saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; pwm=0; wrap=0; period_cnt=0.
  - active_duty=shadow=INIT_DUTY; pending=0; prev_count=0.
  - duty_ready=1.
- prev_count registers count every cycle.
- wrap_det (combinational) = (prev_count == all-ones) && (count == 0).
  - An upstream counter reset from any other value is not a wrap.
- Handshake:
  - duty_ready = !pending.
  - A transfer occurs when duty_valid && duty_ready at a rising edge.
  - duty_valid may be held while ready is low; the value is taken on the first cycle ready is high.
- FSM states are IDLE, SYNC and RUN. en=0 in any state forces IDLE on the next edge, with priority over all other transitions.
- IDLE:
  - pwm=0; period_cnt cleared.
  - A transfer writes both shadow and active_duty directly; pending stays 0.
  - en=1 → SYNC.
- SYNC:
  - pwm=0; waits for alignment to a period start.
  - On wrap_det: go to RUN, active_duty ← shadow, pending ← 0.
- RUN:
  - Each edge: pwm ← (count < duty_eff).
  - duty_eff = shadow when wrap_det && pending; otherwise active_duty.
  - On wrap_det: active_duty ← duty_eff, pending ← 0, wrap ← 1 for one cycle, period_cnt ← period_cnt+1 (saturates at all-ones, no roll-over).
- Pending rules:
  - In SYNC or RUN, a transfer writes shadow and sets pending=1.
  - Transfer and wrap_det in the same cycle (possible only with pending=0): duty_in bypasses straight to active_duty and is used for this period's comparison; pending stays 0.
- Latency: pwm reflects the count sampled one clock earlier (1-cycle registered latency).
- Duty boundaries:
  - duty=0 → pwm constantly 0.
  - duty=255 → high for counts 0..254, low at 255.
  - No 100% duty is available.
- The first RUN period begins at the count==0 that follows a 255; SYNC never produces a partial period.
- en deasserted mid-period: pwm=0 on the next edge; a pending shadow value is kept but not applied.
- Re-entering SYNC from IDLE with pending=1: the pending value is applied at the first wrap.
- rst asserted mid-operation: all registers return to their reset values immediately; a pending transfer is lost.

Decomposition:
- Package pwm_pkg:
  - state encoding (IDLE=2'b00, SYNC=2'b01, RUN=2'b10);
  - CNT_MAX = {WIDTH{1'b1}};
  - PCNT_MAX.
- Sub-module wrap_detect: holds prev_count and produces wrap_det. It is reusable by other consumers of the counter.

Test Plan:
- rst=0 for 10 ns, then release with en=0 → pwm=0, duty_ready=1, period_cnt=0, wrap=0.
- In IDLE, transfer duty=64, set en=1; counter running from 0 → state SYNC until 255→0, then per period pwm high for 64 cycles and low for 192; wrap pulses once every 256 cycles; period_cnt increments.
- In RUN mid-period (count=100), transfer duty=200 → duty_ready drops to 0; current period keeps duty 64; next period pwm high for 200 cycles; duty_ready returns to 1 after the wrap.
- Transfer duty=10 exactly on the cycle count goes 255→0 with pending=0 → that period has pwm high for 10 cycles; pending stays 0.
- duty=0, then duty=255 → pwm never high; then high for 255 cycles and low for exactly 1 cycle per period.
- Drop en at count=30 in RUN → pwm=0 and period_cnt=0 on the next edge. Pulse rst low mid-run → immediate reset values, active_duty=INIT_DUTY.
